rtr_route_filter_sched: RTL

//  Time-multiplexes one shared route filter (shared_filter=1 build) among the input VCs of a port.

---
 rtl/rtr_route_filter_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rtr_route_filter_sched.sv
// ============================================================================
// Module      : rtr_route_filter_sched
// Description : Round-robin scheduler that time-multiplexes one shared route
//               filter among the input VCs of a router port. It is a two-stage
//               pipeline: grant -> filter input register -> result capture.
//               Optional macro RTR_ROUTE_FILTER_SCHED_STICKY_ERR_EN makes the
//               error outputs sticky (OR-accumulated until reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtr_route_filter_sched #(
    parameter int NUM_VCS              = 4,
    parameter int NUM_PORTS            = 5,
    parameter int NUM_RESOURCE_CLASSES = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_VCS-1:0]                      req_vc_i,
    input  logic [NUM_VCS*NUM_PORTS-1:0]            req_op_i,
    input  logic [NUM_VCS*NUM_RESOURCE_CLASSES-1:0] req_orc_i,
    input  logic [NUM_VCS-1:0]                      flush_vc_i,
    output logic [NUM_VCS-1:0]                      gnt_vc_o,
    output logic                                    filt_valid_o,
    output logic [NUM_VCS-1:0]                      filt_vc_o,
    output logic [NUM_PORTS-1:0]                    filt_in_op_o,
    output logic [NUM_RESOURCE_CLASSES-1:0]         filt_in_orc_o,
    input  logic [NUM_PORTS-1:0]                    filt_out_op_i,
    input  logic [NUM_RESOURCE_CLASSES-1:0]         filt_out_orc_i,
    input  logic [1:0]                              filt_errors_i,
    output logic [NUM_VCS-1:0]                      done_vc_o,
    output logic [NUM_PORTS-1:0]                    res_op_o,
    output logic [NUM_RESOURCE_CLASSES-1:0]         res_orc_o,
    output logic [1:0]                              errors_o
);

    localparam int PTR_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam logic [PTR_W:0]   C_NUM_VCS = (PTR_W+1)'(NUM_VCS);
    localparam logic [PTR_W-1:0] C_LAST_VC = PTR_W'(NUM_VCS-1);

    logic [PTR_W-1:0]                rr_ptr_q,      rr_ptr_d;
    logic                            filt_valid_q,  filt_valid_d;
    logic [NUM_VCS-1:0]              filt_vc_q,     filt_vc_d;
    logic [NUM_PORTS-1:0]            filt_in_op_q,  filt_in_op_d;
    logic [NUM_RESOURCE_CLASSES-1:0] filt_in_orc_q, filt_in_orc_d;
    logic [NUM_VCS-1:0]              done_vc_q,     done_vc_d;
    logic [NUM_PORTS-1:0]            res_op_q,      res_op_d;
    logic [NUM_RESOURCE_CLASSES-1:0] res_orc_q,     res_orc_d;
    logic [1:0]                      errors_q,      errors_d;

    logic [NUM_VCS-1:0]              eligible;
    logic [PTR_W:0]                  cand_sum;
    logic [PTR_W:0]                  cand;
    logic                            gnt_any;
    logic [PTR_W-1:0]                gnt_idx;
    logic [NUM_VCS-1:0]              gnt_vc;
    logic [NUM_PORTS-1:0]            sel_op;
    logic [NUM_RESOURCE_CLASSES-1:0] sel_orc;
    logic                            capture;

    // Round-robin search: first eligible VC at or after the pointer, wrapping.
    always_comb begin
        eligible = req_vc_i & ~flush_vc_i;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            cand     = (cand_sum >= C_NUM_VCS) ? (cand_sum - C_NUM_VCS) : cand_sum;
            if (!gnt_any && eligible[cand[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PTR_W-1:0];
            end
        end
        gnt_vc = gnt_any ? (NUM_VCS'(1) << gnt_idx) : '0;
    end

    // Packed request vectors carry VC0 in the most significant slice.
    always_comb begin
        sel_op  = '0;
        sel_orc = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (gnt_vc[v]) begin
                sel_op  = sel_op  | req_op_i[(NUM_VCS-1-v)*NUM_PORTS +: NUM_PORTS];
                sel_orc = sel_orc | req_orc_i[(NUM_VCS-1-v)*NUM_RESOURCE_CLASSES +: NUM_RESOURCE_CLASSES];
            end
        end
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        filt_valid_d  = gnt_any;
        filt_vc_d     = gnt_vc;
        filt_in_op_d  = filt_in_op_q;
        filt_in_orc_d = filt_in_orc_q;
        if (gnt_any) begin
            rr_ptr_d      = (gnt_idx == C_LAST_VC) ? '0 : gnt_idx + PTR_W'(1);
            filt_in_op_d  = sel_op;
            filt_in_orc_d = sel_orc;
        end
    end

    // A flush hitting the VC currently in the filter stage drops its result.
    always_comb begin
        capture   = filt_valid_q & ~(|(filt_vc_q & flush_vc_i));
        done_vc_d = capture ? filt_vc_q : '0;
        res_op_d  = capture ? filt_out_op_i  : res_op_q;
        res_orc_d = capture ? filt_out_orc_i : res_orc_q;
`ifdef RTR_ROUTE_FILTER_SCHED_STICKY_ERR_EN
        errors_d  = filt_valid_q ? (errors_q | filt_errors_i) : errors_q;
`else
        errors_d  = capture ? filt_errors_i : 2'b00;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            filt_valid_q  <= 1'b0;
            filt_vc_q     <= '0;
            filt_in_op_q  <= '0;
            filt_in_orc_q <= '0;
            done_vc_q     <= '0;
            res_op_q      <= '0;
            res_orc_q     <= '0;
            errors_q      <= 2'b00;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            filt_valid_q  <= filt_valid_d;
            filt_vc_q     <= filt_vc_d;
            filt_in_op_q  <= filt_in_op_d;
            filt_in_orc_q <= filt_in_orc_d;
            done_vc_q     <= done_vc_d;
            res_op_q      <= res_op_d;
            res_orc_q     <= res_orc_d;
            errors_q      <= errors_d;
        end
    end

    assign gnt_vc_o      = gnt_vc;
    assign filt_valid_o  = filt_valid_q;
    assign filt_vc_o     = filt_vc_q;
    assign filt_in_op_o  = filt_in_op_q;
    assign filt_in_orc_o = filt_in_orc_q;
    assign done_vc_o     = done_vc_q;
    assign res_op_o      = res_op_q;
    assign res_orc_o     = res_orc_q;
    assign errors_o      = errors_q;

endmodule

`default_nettype wire
